// File: rtl/request_queue_bank.sv
// Per-requester FIFO bank feeding a round-robin arbiter: request mirrors FIFO
// occupancy, and a legal one-hot grant pops that channel onto a registered output.
module request_queue_bank #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int SRC_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        push_valid,
  input  logic [N_REQ*DATA_W-1:0] push_data,
  output logic [N_REQ-1:0]        push_ready,
  output logic [N_REQ-1:0]        request,
  input  logic [N_REQ-1:0]        grant,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src,
  output logic                    grant_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]  wr_ptr [N_REQ];
  logic [PTR_W-1:0]  rd_ptr [N_REQ];
  logic [DATA_W-1:0] mem    [N_REQ][DEPTH];

  logic [N_REQ-1:0]  empty;
  logic [N_REQ-1:0]  full;
  logic [N_REQ-1:0]  push_fire;
  logic [N_REQ-1:0]  pop_fire;
  logic [SRC_W-1:0]  sel_idx;
  logic              grant_one_hot;
  logic              pop_legal;
  logic              grant_bad;
  logic [DATA_W-1:0] head_data;

  // Extra pointer MSB separates full (MSBs differ, index equal) from empty.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][PTR_W-1] != rd_ptr[i][PTR_W-1]) &&
                 (wr_ptr[i][ADDR_W-1:0] == rd_ptr[i][ADDR_W-1:0]);
    end
  end

  assign push_ready = ~full;
  assign request    = ~empty;
  assign push_fire  = push_valid & push_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_idx = SRC_W'(i);
    end
  end

  // A grant to an empty channel (including one being pushed this very cycle) is illegal.
  assign grant_one_hot = $onehot(grant);
  assign pop_legal     = grant_one_hot && request[sel_idx];
  assign grant_bad     = (grant != '0) && !pop_legal;
  assign pop_fire      = grant & {N_REQ{pop_legal}};
  assign head_data     = mem[sel_idx][rd_ptr[sel_idx][ADDR_W-1:0]];

  // NOTE: the storage array is deliberately not reset; empty pointers make its
  // contents unobservable, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (!reset && push_fire[i]) begin
        mem[i][wr_ptr[i][ADDR_W-1:0]] <= push_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (push_fire[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop_fire[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
      end
    end
  end

  // out_data/out_src hold their last popped values when nothing pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      grant_err <= 1'b0;
    end else begin
      out_valid <= pop_legal;
      grant_err <= grant_bad;
      if (pop_legal) begin
        out_data <= head_data;
        out_src  <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_request_queue_bank.sv
// Self-checking bench for request_queue_bank: per-channel queue model, directed
// scenarios and a randomized run with a round-robin arbiter loop.
module tb_request_queue_bank;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  push_valid;
  logic [N*DW-1:0] push_data;
  logic [N-1:0]  push_ready;
  logic [N-1:0]  request;
  logic [N-1:0]  grant;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_src;
  logic          grant_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per channel plus expected output registers.
  logic [DW-1:0] mq [N][$];
  logic [N-1:0]  m_ready, m_req, pre_ready, pre_req;
  logic          exp_ov, exp_err;
  logic [DW-1:0] exp_od;
  logic [SW-1:0] exp_os;

  request_queue_bank #(.N_REQ(N), .DATA_W(DW), .DEPTH(D), .SRC_W(SW)) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .request(request), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  // Drives one cycle, samples pre-edge status, advances the model, returns #1 after the edge.
  task automatic cycle(input logic [N-1:0] pv, input logic [N*DW-1:0] pd,
                       input logic [N-1:0] g, input logic r);
    int idx;
    push_valid = pv; push_data = pd; grant = g; reset = r;
    #1;
    pre_ready = push_ready;
    pre_req   = request;
    for (int i = 0; i < N; i++) begin
      m_ready[i] = (mq[i].size() < D);
      m_req[i]   = (mq[i].size() > 0);
    end
    if (r) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_ov = 1'b0; exp_err = 1'b0; exp_od = '0; exp_os = '0;
    end else begin
      idx = -1;
      if ($countones(g) == 1) begin
        for (int i = 0; i < N; i++) if (g[i] && mq[i].size() > 0) idx = i;
      end
      exp_ov  = (idx >= 0);
      exp_err = (g != '0) && (idx < 0);
      if (idx >= 0) begin
        exp_od = mq[idx].pop_front();
        exp_os = SW'(idx);
      end
      for (int i = 0; i < N; i++) if (pv[i] && m_ready[i]) mq[i].push_back(pd[i*DW +: DW]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(4'hF, N*DW'($urandom), '0, 1'b1);
    cycle(4'hF, N*DW'($urandom), '0, 1'b1);
    checks++; if (request !== 4'h0) begin failures++; $display("FAIL reset_request got=%h want=0", request); end
    checks++; if (push_ready !== 4'hF) begin failures++; $display("FAIL reset_ready got=%h want=f", push_ready); end
    checks++; if (out_valid !== 1'b0 || grant_err !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
      failures++; $display("FAIL reset_outputs valid=%b err=%b data=%h src=%0d want all 0", out_valid, grant_err, out_data, out_src);
    end
    cycle('0, '0, 4'b0001, 1'b0);
    checks++; if (grant_err !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_nothing_stored err=%b valid=%b want err=1 valid=0", grant_err, out_valid);
    end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] want;
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0100, (N*DW)'(8'h10 + k) << 16, '0, 1'b0);
      checks++; if (pre_ready[2] !== (k < 4)) begin
        failures++; $display("FAIL fill_ready k=%0d got=%b want=%b", k, pre_ready[2], (k < 4));
      end
    end
    for (int k = 0; k < 4; k++) begin
      cycle('0, '0, 4'b0100, 1'b0);
      want = 8'h10 + 8'(k);
      checks++; if (out_valid !== 1'b1 || out_data !== want || out_src !== 2'd2) begin
        failures++; $display("FAIL drain k=%0d valid=%b data=%h src=%0d want 1/%h/2", k, out_valid, out_data, out_src, want);
      end
    end
    checks++; if (request !== 4'h0 || push_ready !== 4'hF) begin
      failures++; $display("FAIL drain_empty request=%h ready=%h want 0/f", request, push_ready);
    end
  endtask

  task automatic test_wrap();
    cycle(4'b0001, 32'h0, '0, 1'b0);
    cycle(4'b0001, 32'h1, '0, 1'b0);
    for (int k = 2; k < 12; k++) begin
      if (k < 10) cycle(4'b0001, (N*DW)'(k), 4'b0001, 1'b0);
      else        cycle('0, '0, 4'b0001, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'(k - 2) || out_src !== 2'd0) begin
        failures++; $display("FAIL wrap k=%0d valid=%b data=%h want 1/%h", k, out_valid, out_data, 8'(k - 2));
      end
    end
    checks++; if (request[0] !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b want=0", request[0]); end
  endtask

  task automatic test_illegal();
    cycle(4'b0011, 32'h0000_2211, '0, 1'b0);
    cycle('0, '0, 4'b0011, 1'b0);
    checks++; if (grant_err !== 1'b1 || out_valid !== 1'b0 || request !== 4'b0011) begin
      failures++; $display("FAIL illegal_multi err=%b valid=%b req=%h want 1/0/3", grant_err, out_valid, request);
    end
    cycle('0, '0, 4'b1000, 1'b0);
    checks++; if (grant_err !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL illegal_empty err=%b valid=%b want 1/0", grant_err, out_valid);
    end
    cycle('0, '0, '0, 1'b0);
    checks++; if (grant_err !== 1'b0 || out_valid !== 1'b0 || out_data !== exp_od) begin
      failures++; $display("FAIL idle_hold err=%b valid=%b data=%h want 0/0/%h", grant_err, out_valid, out_data, exp_od);
    end
    cycle('0, '0, 4'b0001, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 2'd0) begin
      failures++; $display("FAIL post_illegal_pop valid=%b data=%h src=%0d want 1/11/0", out_valid, out_data, out_src);
    end
    cycle('0, '0, '0, 1'b1);
  endtask

  task automatic test_arbiter();
    int seq [6] = '{0, 1, 3, 0, 1, 3};
    int last = N - 1;
    int c;
    logic [N-1:0] g;
    cycle(4'b1011, 32'hD0_00_B0_A0, '0, 1'b0);
    cycle(4'b1011, 32'hD1_00_B1_A1, '0, 1'b0);
    checks++; if (request !== 4'b1011) begin failures++; $display("FAIL arb_preload got=%h want=b", request); end
    for (int s = 0; s < 6; s++) begin
      g = '0;
      for (int off = N; off >= 1; off--) begin
        if (request[(last + off) % N]) begin c = (last + off) % N; end
      end
      g[c] = 1'b1;
      last = c;
      cycle('0, '0, g, 1'b0);
      checks++; if (out_valid !== 1'b1 || grant_err !== 1'b0 || out_src !== 2'(seq[s]) || out_data !== exp_od) begin
        failures++; $display("FAIL arb s=%0d valid=%b err=%b src=%0d data=%h want 1/0/%0d/%h",
                             s, out_valid, grant_err, out_src, out_data, seq[s], exp_od);
      end
    end
    checks++; if (request !== 4'h0) begin failures++; $display("FAIL arb_drained got=%h want=0", request); end
  endtask

  task automatic test_full_edge();
    for (int k = 0; k < 4; k++) cycle(4'b0010, (N*DW)'(8'h40 + k) << 8, '0, 1'b0);
    cycle(4'b0010, 32'h0000_9900, 4'b0010, 1'b0);
    checks++; if (pre_ready[1] !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h40 || push_ready[1] !== 1'b1) begin
      failures++; $display("FAIL full_edge pre_ready=%b valid=%b data=%h ready=%b want 0/1/40/1",
                           pre_ready[1], out_valid, out_data, push_ready[1]);
    end
    for (int k = 1; k < 4; k++) begin
      cycle('0, '0, 4'b0010, 1'b0);
      checks++; if (out_data !== 8'(8'h40 + k)) begin
        failures++; $display("FAIL full_drop k=%0d data=%h want=%h", k, out_data, 8'(8'h40 + k));
      end
    end
    checks++; if (request[1] !== 1'b0) begin failures++; $display("FAIL full_dropped got=%b want=0", request[1]); end
    // Push into an empty channel while granting it: grant is illegal, push lands.
    cycle(4'b0100, 32'h0077_0000, 4'b0100, 1'b0);
    checks++; if (grant_err !== 1'b1 || out_valid !== 1'b0 || request[2] !== 1'b1) begin
      failures++; $display("FAIL empty_edge err=%b valid=%b req=%b want 1/0/1", grant_err, out_valid, request[2]);
    end
    cycle(4'hF, 32'h0403_0201, '0, 1'b0);
    cycle(4'hF, 32'h0807_0605, 4'b0001, 1'b1);
    checks++; if (request !== 4'h0 || push_ready !== 4'hF || out_valid !== 1'b0 || out_data !== 8'h00) begin
      failures++; $display("FAIL mid_reset req=%h ready=%h valid=%b data=%h want 0/f/0/00",
                           request, push_ready, out_valid, out_data);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    int sel;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      g = N'(1) << $urandom_range(0, N - 1);
      else if (sel <= 7) g = '0;
      else               g = N'($urandom);
      cycle(N'($urandom), (N*DW)'($urandom), g, ($urandom_range(0, 49) == 0));
      checks++; if (pre_ready !== m_ready || pre_req !== m_req) begin
        failures++; $display("FAIL rand_status n=%0d ready=%h req=%h want %h/%h", n, pre_ready, pre_req, m_ready, m_req);
      end
      checks++; if (out_valid !== exp_ov || grant_err !== exp_err || out_data !== exp_od || out_src !== exp_os) begin
        failures++; $display("FAIL rand_out n=%0d v=%b e=%b d=%h s=%0d want %b/%b/%h/%0d",
                             n, out_valid, grant_err, out_data, out_src, exp_ov, exp_err, exp_od, exp_os);
      end
    end
  endtask

  initial begin
    reset = 1'b1; push_valid = '0; push_data = '0; grant = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_illegal();
    test_arbiter();
    test_full_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
